// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and control width shared by execute-stage ALU users
package alu_pkg;
   localparam int ALU_CTRL_W = 3;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, unknown codes yield zero
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  result,
   output logic              zero
);
   // select the operation; SLT is an unsigned compare
   always_comb begin
      result = (ctrl == CTRL_W'(ALU_AND)) ? a & b :
               (ctrl == CTRL_W'(ALU_OR))  ? a | b :
               (ctrl == CTRL_W'(ALU_ADD)) ? a + b :
               (ctrl == CTRL_W'(ALU_SUB)) ? a - b :
               (ctrl == CTRL_W'(ALU_SLT)) ? WIDTH'(a < b) : '0;
      zero   = (result == '0);
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters with a registered result
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero
);
   logic              ptr;
   logic              can_accept;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic [WIDTH-1:0]  alu_result;
   logic              alu_zero;

   // grant follows the pointer only under contention; ready is gated by reset and result-slot space
   always_comb begin
      can_accept = !rsp_valid | rsp_ready;
      grant0     = req0_valid & (!req1_valid | !ptr);
      grant1     = req1_valid & (!req0_valid | ptr);
      req0_ready = rst_n & grant0 & can_accept;
      req1_ready = rst_n & grant1 & can_accept;
      accept     = req0_ready | req1_ready;
      alu_ctrl   = grant1 ? req1_ctrl : req0_ctrl;
      alu_a      = grant1 ? req1_a : req0_a;
      alu_b      = grant1 ? req1_b : req0_b;
   end

   alu_core #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
      .ctrl   (alu_ctrl),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // capture the launched result and hand priority to the loser; drain clears valid only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else if (accept) begin
         ptr        <= !req1_ready;
         rsp_valid  <= 1'b1;
         rsp_id     <= req1_ready;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one execute-stage ALU datapath between two requesters, e.g. the main pipeline issue slot (port 0) and a secondary address/branch-compare unit (port 1).
- Arbitrates round-robin and launches the selected operation into the ALU.
- Registers the result together with the requester ID.
- Holds that result until the consumer accepts it.

Parameters:
- WIDTH, 32: operand and result width.
- CTRL_W, 3: ALU control code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctrl  in  CTRL_W  requester 0 ALU control code.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  1 when rsp_result == 0.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - Priority pointer = port 0.
  - req*_ready are combinational and read 0 during reset.
- Handshake: a transfer occurs when valid & ready on the same edge.
  - Requesters must hold valid, ctrl, a and b stable until accepted.
  - valid must not depend on ready.
- can_accept = !rsp_valid | rsp_ready.
  - A result being drained and a new operation being accepted in the same cycle gives full throughput: 1 op/cycle.
- Grant (combinational):
  - Only one valid requester: it wins.
  - Both valid: the port named by the priority pointer wins.
  - reqN_ready = grantN & can_accept. At most one ready is high per cycle.
- Pointer update: only on an accepted transfer; pointer <= the port that was not granted.
  - A stalled grant (can_accept=0) does not move the pointer.
  - The winner stays the same while stalled, so the grant cannot flip while a requester holds its request.
- Latency: operation accepted at edge N gives rsp_valid=1 with result after edge N (visible in cycle N+1).
- Result register:
  - On accept: load rsp_result, rsp_zero, rsp_id, and set rsp_valid=1.
  - On rsp_ready with no new accept: clear rsp_valid.
  - Data outputs keep their last value when not valid.
- ALU control codes:
  - 000 AND.
  - 001 OR.
  - 010 ADD, modulo 2^WIDTH, carry dropped.
  - 110 SUB, A−B modulo 2^WIDTH.
  - 111 SLT, unsigned compare: result 1 if A<B else 0.
  - Any other code: result 0, zero=1.
- rsp_zero is computed from the result for every code, not only SLT.
- Fairness: with both ports continuously valid and rsp_ready=1, grants strictly alternate 0,1,0,1. No port waits more than one accepted transfer.
- Backpressure: while rsp_valid=1 and rsp_ready=0, both readys are 0 and the register holds.
- Reset mid-operation: a pending result is discarded and the pointer returns to 0. Requesters must re-present the operation.
- State machine (implicit in rsp_valid):
  - EMPTY to FULL on accept.
  - FULL stays FULL on drain+accept or on hold.
  - FULL to EMPTY on drain without accept.

Decomposition:
- Shared package alu_pkg: the ALU control code constants (AND/OR/ADD/SUB/SLT) and the CTRL_W width. These are shared with the execute-stage ALU and the ALU control decoder.
- One sub-module, alu_core: purely combinational, with inputs ctrl, a, b and outputs result and zero.
- The arbiter, pointer and result register stay in alu_share_arbiter.

Test Plan:
- Reset: drive rst_n=0 mid-run with rsp_valid=1 → rsp_valid=0 immediately (asynchronous); next simultaneous request is granted to port 0.
- Single op: req0 ADD a=0x0000_0005, b=0x0000_0003, rsp_ready=1 → one cycle later rsp_valid=1, rsp_id=0, result=0x8, zero=0.
- Arithmetic edges:
  - SUB 7−7 → result 0, zero=1.
  - ADD 0xFFFF_FFFF+1 → 0, zero=1.
  - SLT a=0x8000_0000, b=1 → 0 (unsigned compare).
  - Code 011 → result 0, zero=1.
- Contention: both ports valid for 6 cycles, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1 and one result per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles with both ports valid → both readys low, result/id stable, pointer unchanged. Release → drain and new accept occur on the same edge; the pending winner is granted.
- Idle port: only req1 valid for 4 consecutive ops → all granted to port 1 back-to-back; pointer ends at 0.
